timer_multi: RTL
================

# timer_multi

Parametrised multi-channel timer, successor to the single-channel prescaled timer in the peripheral set. Each of `CHANNELS` independent channels runs its own prescaler and a `WIDTH`-bit up-counter. A channel counts from a load value to all-ones, then raises a sticky interrupt, in one-shot or auto-reload mode. All logic runs on one clock; prescaling is a clock enable, not a derived clock. The block sits beside the CPU interrupt logic and the register-file decode.

## Interface
- `WIDTH`, 16: counter and load-value width.
- `CHANNELS`, 2: number of independent channels (1..8).
- `PSEL_W`, 3: prescaler select width; prescaler counter is `2**PSEL_W-1` bits.
- `clk_in`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `ch_en`  in  CHANNELS: per-channel enable; low freezes that channel completely.
- `ch_go`  in  CHANNELS: per-channel start (high) / abort (low).
- `ch_auto_load`  in  CHANNELS: 1 = reload and continue after rollover; 0 = one-shot.
- `ch_psel`  in  PSEL_W*CHANNELS: tick divide = 2**psel; channel i at bits [i*PSEL_W +: PSEL_W].
- `ch_load`  in  WIDTH*CHANNELS: start/reload value; channel i at [i*WIDTH +: WIDTH].
- `ch_int_ack`  in  CHANNELS: one-cycle pulse clears that channel's interrupt and overflow flags.
- `tmr_int`  out  CHANNELS: sticky per-channel interrupt; reset 0.
- `tmr_ovf`  out  CHANNELS: rollover occurred while `tmr_int` already set; reset 0.
- `tmr_irq`  out  1: OR of `tmr_int`; reset 0.
- `ch_busy`  out  CHANNELS: channel in RUN; reset 0.
- `ch_count`  out  WIDTH*CHANNELS: live counter values; reset 0.

## Operation
- Per-channel FSM with three states:
  - IDLE: on `go`=1, load count ← `ch_load`, clear prescaler, go to RUN.
  - RUN: the prescaler increments every cycle. A tick occurs in a cycle where the low `psel` prescaler bits are all ones; `psel`=0 ticks every cycle.
    - Tick with count ≠ MAX: count+1.
    - Tick with count = MAX: set `tmr_int`. If `auto_load`, count ← `ch_load` and stay in RUN; else hold count at MAX and go to DONE.
  - DONE: hold; `go`=0 → IDLE. Holding `go` high does not retrigger.
- `go`=0 in RUN or DONE: go to IDLE next cycle. Count holds its last value; flags are untouched.
- `en`=0 in any state: state, count, and prescaler freeze. Flags still respond to `ch_int_ack`.
- Flags:
  - Rollover while `tmr_int`=1 sets `tmr_ovf`.
  - Rollover and ack in the same cycle: set wins; `tmr_int`=1 and `tmr_ovf`=0 afterwards.
- `ch_load` and `auto_load` are sampled at load/reload time only. `psel` is live; changing it mid-run changes the tick rate from the next cycle, with no prescaler clear.
- Arithmetic is unsigned, modulo 2**WIDTH. MAX = all-ones.

## Timing
- `go` sampled high in IDLE at cycle N: at N+1, `ch_busy`=1 and count = load.
- Interrupt arrives `(MAX-load+1)*2**psel` cycles after N+1; `tmr_int` is visible on that edge.
- Auto-reload period is `(MAX-load+1)*2**psel` cycles, with no dead cycle.
- Load = MAX: interrupt after exactly `2**psel` cycles.
- `rst` mid-operation: next cycle all channels are in IDLE, all outputs are 0, and the prescalers are 0.
- All outputs are registered except `tmr_irq`, which is the OR of registered bits.

## Structure
- Package `timer_pkg` holds:
  - state encodings `T_IDLE`=2'b00, `T_RUN`=2'b01, `T_DONE`=2'b10;
  - `PSEL_W` default;
  - tick-detect function (low-n-bits-all-ones).
- Sub-module `timer_channel` holds one FSM, prescaler, counter and flags. The top level `timer_multi` instantiates `timer_channel` `CHANNELS` times via generate, slices the vectors and ORs `tmr_irq`.

## Test plan
- WIDTH=16, ch0 load=16'hFFFE, psel=0, go at N → count FFFE@N+1, FFFF@N+2, `tmr_int`=1@N+3, `ch_busy`=0, DONE holds while `go`=1.
- ch1 load=16'hFFF0, psel=2, auto_load=1, no ack → `tmr_int` first at 64 cycles after N+1. At 128 cycles, `tmr_ovf`=1. Count is 16'hFFF0 immediately after each rollover.
- Ack pulse coinciding with an auto-reload rollover → `tmr_int`=1 and `tmr_ovf`=0 after that edge.
- `en`=0 for 10 cycles mid-run → count and prescaler frozen; interrupt delayed by exactly 10 cycles.
- `go` dropped mid-run → IDLE next cycle, `ch_busy`=0, count held. Re-assert `go` → reload from `ch_load`.
- `rst` asserted while both channels run with `tmr_int`=1 → all outputs 0 on the next edge; the other channel is unaffected by channel-specific stimulus throughout.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the multi-channel timer.
//   T_IDLE / T_RUN / T_DONE : per-channel state encodings
//   PSEL_W_DEF              : default prescaler-select width (supported up to 5)
//   tick_detect()           : 1 when the low n bits of a prescaler value are all ones
package timer_pkg;

  localparam int unsigned PSEL_W_DEF = 3;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_RUN  = 2'b01;
  localparam logic [1:0] T_DONE = 2'b10;

  // n = 0 always reports a tick, so psel = 0 divides by one.
  function automatic logic tick_detect(input logic [31:0] presc, input logic [4:0] n);
    logic hit;
    hit = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i < {27'd0, n}) && !presc[i]) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel -- FSM, free-running prescaler, up-counter
// and sticky interrupt/overflow flags.
//   clk_in, rst      : clock, synchronous active-high reset
//   en               : low freezes state, count and prescaler (flags still ack)
//   go               : start (high) / abort (low)
//   auto_load        : reload on rollover instead of stopping
//   psel             : tick divide = 2**psel, live
//   load             : start/reload value
//   int_ack          : clears tmr_int and tmr_ovf
//   tmr_int, tmr_ovf : sticky interrupt, rollover-while-pending flag
//   busy             : channel is in RUN
//   count            : live counter value
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PSEL_W = PSEL_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              go,
  input  logic              auto_load,
  input  logic [PSEL_W-1:0] psel,
  input  logic [WIDTH-1:0]  load,
  input  logic              int_ack,
  output logic              tmr_int,
  output logic              tmr_ovf,
  output logic              busy,
  output logic [WIDTH-1:0]  count
);

  localparam int unsigned PW = (2 ** PSEL_W) - 1;

  logic [1:0]       state, state_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic [WIDTH-1:0] count_nx;
  logic             tick, rollover, int_nx, ovf_nx;

  always_comb begin
    tick     = tick_detect(32'(presc), 5'(psel));
    state_nx = state;
    count_nx = count;
    presc_nx = presc;
    rollover = 1'b0;
    if (en) begin
      case (state)
        T_IDLE: begin
          if (go) begin
            state_nx = T_RUN;
            count_nx = load;
            presc_nx = '0;
          end
        end
        T_RUN: begin
          // Abort takes priority over a tick in the same cycle; count holds.
          if (!go) begin
            state_nx = T_IDLE;
          end else begin
            presc_nx = presc + {{(PW-1){1'b0}}, 1'b1};
            if (tick) begin
              if (&count) begin
                rollover = 1'b1;
                if (auto_load) count_nx = load;
                else           state_nx = T_DONE;
              end else begin
                count_nx = count + {{(WIDTH-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        T_DONE: begin
          if (!go) state_nx = T_IDLE;
        end
        default: state_nx = T_IDLE;
      endcase
    end
  end

  // A rollover coinciding with an ack leaves only the fresh interrupt set.
  always_comb begin
    int_nx = tmr_int;
    ovf_nx = tmr_ovf;
    if (rollover) begin
      int_nx = 1'b1;
      ovf_nx = int_ack ? 1'b0 : (tmr_ovf | tmr_int);
    end else if (int_ack) begin
      int_nx = 1'b0;
      ovf_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= T_IDLE;
      count   <= '0;
      presc   <= '0;
      tmr_int <= 1'b0;
      tmr_ovf <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      presc   <= presc_nx;
      tmr_int <= int_nx;
      tmr_ovf <= ovf_nx;
      busy    <= (state_nx == T_RUN);
    end
  end

endmodule

// File: rtl/timer_multi.sv
// timer_multi: CHANNELS independent prescaled timers on one clock.
//   clk_in, rst   : clock, synchronous active-high reset
//   ch_en         : per-channel enable (freeze when low)
//   ch_go         : per-channel start / abort
//   ch_auto_load  : per-channel auto-reload select
//   ch_psel       : PSEL_W bits per channel, channel i at [i*PSEL_W +: PSEL_W]
//   ch_load       : WIDTH bits per channel, channel i at [i*WIDTH +: WIDTH]
//   ch_int_ack    : per-channel flag clear pulse
//   tmr_int       : sticky per-channel interrupt
//   tmr_ovf       : per-channel overflow (rollover while interrupt pending)
//   tmr_irq       : OR of tmr_int
//   ch_busy       : per-channel RUN indicator
//   ch_count      : live counters, channel i at [i*WIDTH +: WIDTH]
module timer_multi
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PSEL_W   = PSEL_W_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [CHANNELS-1:0]          ch_go,
  input  logic [CHANNELS-1:0]          ch_auto_load,
  input  logic [PSEL_W*CHANNELS-1:0]   ch_psel,
  input  logic [WIDTH*CHANNELS-1:0]    ch_load,
  input  logic [CHANNELS-1:0]          ch_int_ack,
  output logic [CHANNELS-1:0]          tmr_int,
  output logic [CHANNELS-1:0]          tmr_ovf,
  output logic                         tmr_irq,
  output logic [CHANNELS-1:0]          ch_busy,
  output logic [WIDTH*CHANNELS-1:0]    ch_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH  (WIDTH),
      .PSEL_W (PSEL_W)
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (ch_en[i]),
      .go        (ch_go[i]),
      .auto_load (ch_auto_load[i]),
      .psel      (ch_psel[i*PSEL_W +: PSEL_W]),
      .load      (ch_load[i*WIDTH +: WIDTH]),
      .int_ack   (ch_int_ack[i]),
      .tmr_int   (tmr_int[i]),
      .tmr_ovf   (tmr_ovf[i]),
      .busy      (ch_busy[i]),
      .count     (ch_count[i*WIDTH +: WIDTH])
    );
  end

  assign tmr_irq = |tmr_int;

endmodule
